// File: rtl/sb_pkg.sv
// ============================================================================
// Module : sb_pkg
// Brief  : Shared flit encodings, nibble field positions and scheduler state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sb_pkg;

   localparam int c_PORTS = 4;

   localparam int c_TYPE_MSB = 3;
   localparam int c_TYPE_LSB = 2;
   localparam int c_DEST_MSB = 1;
   localparam int c_DEST_LSB = 0;

   localparam logic [1:0] c_FLIT_HEADER  = 2'b11;
   localparam logic [1:0] c_FLIT_PAYLOAD = 2'b10;
   localparam logic [1:0] c_FLIT_TAIL    = 2'b01;
   localparam logic [1:0] c_FLIT_NULL    = 2'b00;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } sched_state_e;

   function automatic logic [1:0] flit_type(input logic [3:0] nib);
      return nib[c_TYPE_MSB:c_TYPE_LSB];
   endfunction

   function automatic logic [1:0] flit_dest(input logic [3:0] nib);
      return nib[c_DEST_MSB:c_DEST_LSB];
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational wrapping priority search starting at rr_ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
   import sb_pkg::*;
#(
   parameter int PORTS = c_PORTS
) (
   input  logic [PORTS-1:0]         req,
   input  logic [$clog2(PORTS)-1:0] rr_ptr,
   output logic [PORTS-1:0]         gnt
);

   localparam int AW = $clog2(PORTS);
   localparam logic [AW:0] c_PORTS_W = (AW+1)'(PORTS);

   logic [AW:0] w_idx;
   logic        w_found;

   // Walk PORTS candidates from rr_ptr, folding the index back below PORTS.
   always_comb begin
      gnt     = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_idx = {1'b0, rr_ptr} + (AW+1)'(i);
         if (w_idx >= c_PORTS_W) begin
            w_idx = w_idx - c_PORTS_W;
         end
         if (!w_found && req[w_idx[AW-1:0]]) begin
            gnt[w_idx[AW-1:0]] = 1'b1;
            w_found            = 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/rr_port_scheduler.sv
// ============================================================================
// Module : rr_port_scheduler
// Brief  : Credit-gated round-robin packet scheduler for one crossbar output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_port_scheduler
   import sb_pkg::*;
#(
   parameter int PORTS   = c_PORTS,
   parameter int CREDITS = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [$clog2(PORTS)-1:0]       r_adr,
   input  logic [PORTS-1:0][3:0]          in_ch_hdr_msn,
   input  logic                           credit_in,
   output logic [PORTS-1:0]               sel,
   output logic                           shift,
   output logic [PORTS-1:0]               pop,
   output logic                           busy,
   output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
   output logic                           err
);

   localparam int AW  = $clog2(PORTS);
   localparam int CW  = (AW > 2) ? AW : 2;
   localparam int CCW = $clog2(CREDITS+1);
   localparam logic [CCW-1:0] c_CREDIT_MAX = CCW'(CREDITS);
   localparam logic [AW-1:0]  c_LAST_PORT  = AW'(PORTS-1);

   sched_state_e   r_state;
   logic [AW-1:0]  r_owner;
   logic [AW-1:0]  r_rr_ptr;
   logic [CCW-1:0] r_credit_cnt;
   logic           r_err;

   logic [PORTS-1:0] w_req;
   logic [PORTS-1:0] w_gnt;
   logic [PORTS-1:0] w_owner_oh;
   logic [AW-1:0]    w_win_idx;
   logic [AW-1:0]    w_next_ptr;
   logic [1:0]       w_own_type;
   logic             w_credit_ok;
   logic [PORTS-1:0] w_sel;
   logic             w_shift;
   logic             w_hdr_err;
   logic             w_tail_done;

   generate
      for (genvar g = 0; g < PORTS; g++) begin : g_req
         assign w_req[g] = (flit_type(in_ch_hdr_msn[g]) == c_FLIT_HEADER) &&
                           (CW'(flit_dest(in_ch_hdr_msn[g])) == CW'(r_adr));
      end
   endgenerate

   rr_arbiter #(
      .PORTS (PORTS)
   ) u_arb (
      .req    (w_req),
      .rr_ptr (r_rr_ptr),
      .gnt    (w_gnt)
   );

   always_comb begin
      w_win_idx = '0;
      for (int i = 0; i < PORTS; i++) begin
         if (w_gnt[i]) begin
            w_win_idx = AW'(i);
         end
      end
   end

   assign w_owner_oh  = PORTS'(1) << r_owner;
   assign w_own_type  = flit_type(in_ch_hdr_msn[r_owner]);
   assign w_credit_ok = (r_credit_cnt != '0);
   assign w_next_ptr  = (r_owner == c_LAST_PORT) ? '0 : r_owner + AW'(1);

   // Grant decision is combinational so a header reaches the output in its own cycle.
   always_comb begin
      w_sel       = '0;
      w_shift     = 1'b0;
      w_hdr_err   = 1'b0;
      w_tail_done = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if ((|w_req) && w_credit_ok) begin
               w_sel   = w_gnt;
               w_shift = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (w_own_type == c_FLIT_HEADER) begin
               w_hdr_err = 1'b1;
            end else if (((w_own_type == c_FLIT_PAYLOAD) || (w_own_type == c_FLIT_TAIL))
                         && w_credit_ok) begin
               w_sel       = w_owner_oh;
               w_shift     = 1'b1;
               w_tail_done = (w_own_type == c_FLIT_TAIL);
            end
         end
         default: ;
      endcase
      if (!rst_n) begin
         w_sel   = '0;
         w_shift = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_owner      <= '0;
         r_rr_ptr     <= '0;
         r_credit_cnt <= c_CREDIT_MAX;
         r_err        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_shift) begin
                  r_owner <= w_win_idx;
                  r_state <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               if (w_tail_done) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= w_next_ptr;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_hdr_err) begin
            r_err <= 1'b1;
         end

         // Simultaneous shift and credit return cancel out.
         if (w_shift && !credit_in) begin
            r_credit_cnt <= r_credit_cnt - CCW'(1);
         end else if (!w_shift && credit_in) begin
            if (r_credit_cnt == c_CREDIT_MAX) begin
               r_err <= 1'b1;
            end else begin
               r_credit_cnt <= r_credit_cnt + CCW'(1);
            end
         end
      end
   end

   assign sel        = w_sel;
   assign pop        = w_sel;
   assign shift      = w_shift;
   assign busy       = (r_state == ST_ACTIVE);
   assign credit_cnt = r_credit_cnt;
   assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rr_port_scheduler.sv
// ============================================================================
// Module : tb_rr_port_scheduler
// Brief  : Scoreboard bench for the round-robin output port scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_port_scheduler;

   localparam logic [1:0] c_ADR = 2'd2;
   localparam logic [3:0] c_H   = {2'b11, c_ADR};
   localparam logic [3:0] c_P   = {2'b10, c_ADR};
   localparam logic [3:0] c_T   = {2'b01, c_ADR};
   localparam logic [3:0] c_N   = 4'h0;
   localparam logic [3:0] c_HO  = {2'b11, 2'd1};

   typedef struct packed {
      logic [3:0] sel;
      logic       shift;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic [1:0]      r_adr;
   logic [3:0][3:0] hdr;
   logic            credit_in;
   logic [3:0]      sel;
   logic            shift;
   logic [3:0]      pop;
   logic            busy;
   logic [2:0]      credit_cnt;
   logic            err;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   rr_port_scheduler #(
      .PORTS   (4),
      .CREDITS (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .r_adr         (r_adr),
      .in_ch_hdr_msn (hdr),
      .credit_in     (credit_in),
      .sel           (sel),
      .shift         (shift),
      .pop           (pop),
      .busy          (busy),
      .credit_cnt    (credit_cnt),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time budget expired (actual running, required finished)");
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] pk(input logic [3:0] f3, input logic [3:0] f2,
                                      input logic [3:0] f1, input logic [3:0] f0);
      return {f3, f2, f1, f0};
   endfunction

   task automatic step(input logic [15:0] fl, input logic cin,
                       input logic [3:0] e_sel, input logic e_shift);
      exp_t e;
      hdr       = fl;
      credit_in = cin;
      q.push_back('{sel: e_sel, shift: e_shift});
      @(negedge clk);
      e = q.pop_front();
      chk_eq("sel",         32'(sel),            32'(e.sel));
      chk_eq("pop",         32'(pop),            32'(e.sel));
      chk_eq("shift",       32'(shift),          32'(e.shift));
      chk_eq("sel_onehot0", 32'($onehot0(sel)),  32'd1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0][3:0] fv;
      rst_n     = 1'b0;
      r_adr     = c_ADR;
      hdr       = '0;
      credit_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state; headers presented during reset must not be forwarded.
      step(pk(c_H, c_H, c_H, c_H), 1'b0, 4'h0, 1'b0);
      chk_eq("rst_busy",   32'(busy),       32'd0);
      chk_eq("rst_credit", 32'(credit_cnt), 32'd4);
      chk_eq("rst_err",    32'(err),        32'd0);
      rst_n = 1'b1;

      // All four channels contend: granted 0,1,2,3, each H,P,P,T.
      for (int k = 0; k < 4; k++) begin
         for (int j = 0; j < 4; j++) fv[j] = (j >= k) ? c_H : c_N;
         step(fv, 1'b1, 4'(1) << k, 1'b1);
         chk_eq("rr_busy", 32'(busy), 32'd1);
         fv[k] = c_P;
         step(fv, 1'b1, 4'(1) << k, 1'b1);
         step(fv, 1'b1, 4'(1) << k, 1'b1);
         fv[k] = c_T;
         step(fv, 1'b1, 4'(1) << k, 1'b1);
         chk_eq("rr_idle", 32'(busy), 32'd0);
      end
      chk_eq("rr_credit", 32'(credit_cnt), 32'd4);
      chk_eq("rr_err",    32'(err),        32'd0);

      // Idle: foreign-destination header and stray payload are ignored without error.
      step(pk(c_P, c_N, c_HO, c_N), 1'b0, 4'h0, 1'b0);
      chk_eq("idle_ignore_err", 32'(err), 32'd0);

      // Channel 2 holds the port through a 3-cycle bubble while channel 0 waits.
      step(pk(c_N, c_H, c_N, c_N), 1'b1, 4'h4, 1'b1);
      repeat (3) step(pk(c_N, c_N, c_N, c_H), 1'b0, 4'h0, 1'b0);
      chk_eq("bubble_busy", 32'(busy), 32'd1);
      step(pk(c_N, c_P, c_N, c_H), 1'b1, 4'h4, 1'b1);
      step(pk(c_N, c_T, c_N, c_H), 1'b1, 4'h4, 1'b1);
      step(pk(c_N, c_N, c_N, c_H), 1'b1, 4'h1, 1'b1);
      step(pk(c_N, c_N, c_N, c_T), 1'b1, 4'h1, 1'b1);

      // Six-flit packet on channel 1 with no returns: four flits, then one per credit.
      step(pk(c_N, c_N, c_H, c_N), 1'b0, 4'h2, 1'b1);
      repeat (3) step(pk(c_N, c_N, c_P, c_N), 1'b0, 4'h2, 1'b1);
      chk_eq("cred_empty", 32'(credit_cnt), 32'd0);
      repeat (2) step(pk(c_N, c_N, c_P, c_N), 1'b0, 4'h0, 1'b0);
      step(pk(c_N, c_N, c_P, c_N), 1'b1, 4'h0, 1'b0);
      chk_eq("cred_one", 32'(credit_cnt), 32'd1);
      step(pk(c_N, c_N, c_P, c_N), 1'b0, 4'h2, 1'b1);
      step(pk(c_N, c_N, c_T, c_N), 1'b1, 4'h0, 1'b0);
      step(pk(c_N, c_N, c_T, c_N), 1'b0, 4'h2, 1'b1);
      chk_eq("cred_done_busy", 32'(busy), 32'd0);
      repeat (4) step(pk(c_N, c_N, c_N, c_N), 1'b1, 4'h0, 1'b0);
      chk_eq("cred_refill", 32'(credit_cnt), 32'd4);
      chk_eq("cred_err",    32'(err),        32'd0);

      // Shift and credit return together at a count of 2 leave it at 2.
      step(pk(c_N, c_N, c_N, c_H), 1'b0, 4'h1, 1'b1);
      step(pk(c_N, c_N, c_N, c_P), 1'b0, 4'h1, 1'b1);
      chk_eq("cred_two", 32'(credit_cnt), 32'd2);
      step(pk(c_N, c_N, c_N, c_P), 1'b1, 4'h1, 1'b1);
      chk_eq("cred_both", 32'(credit_cnt), 32'd2);
      step(pk(c_N, c_N, c_N, c_T), 1'b1, 4'h1, 1'b1);
      chk_eq("cred_both_tail", 32'(credit_cnt), 32'd2);
      repeat (2) step(pk(c_N, c_N, c_N, c_N), 1'b1, 4'h0, 1'b0);

      // Credit return at full count saturates and flags an error.
      step(pk(c_N, c_N, c_N, c_N), 1'b1, 4'h0, 1'b0);
      chk_eq("sat_credit", 32'(credit_cnt), 32'd4);
      chk_eq("sat_err",    32'(err),        32'd1);

      // Reset in the second cycle of a packet abandons it.
      step(pk(c_H, c_N, c_N, c_N), 1'b0, 4'h8, 1'b1);
      rst_n = 1'b0;
      step(pk(c_P, c_N, c_N, c_N), 1'b0, 4'h0, 1'b0);
      chk_eq("mid_rst_busy",   32'(busy),           32'd0);
      chk_eq("mid_rst_credit", 32'(credit_cnt),     32'd4);
      chk_eq("mid_rst_err",    32'(err),            32'd0);
      chk_eq("mid_rst_ptr",    32'(dut.r_rr_ptr),   32'd0);
      rst_n = 1'b1;
      step(pk(c_H, c_N, c_N, c_N), 1'b1, 4'h8, 1'b1);
      step(pk(c_T, c_N, c_N, c_N), 1'b1, 4'h8, 1'b1);

      // Owner presents a second header mid-packet: error, not forwarded.
      step(pk(c_N, c_N, c_H, c_N), 1'b1, 4'h2, 1'b1);
      step(pk(c_N, c_N, c_H, c_N), 1'b0, 4'h0, 1'b0);
      chk_eq("hdr_err",  32'(err),  32'd1);
      chk_eq("hdr_busy", 32'(busy), 32'd1);
      step(pk(c_N, c_N, c_P, c_N), 1'b1, 4'h2, 1'b1);
      step(pk(c_N, c_N, c_T, c_N), 1'b1, 4'h2, 1'b1);
      step(pk(c_N, c_N, c_N, c_N), 1'b0, 4'h0, 1'b0);
      chk_eq("hdr_err_sticky", 32'(err),        32'd1);
      chk_eq("hdr_credit",     32'(credit_cnt), 32'd4);
      chk_eq("sb_drained",     32'(q.size()),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
